// File: rtl/keypad_replay_tx.sv
// keypad_replay_tx
// Scripted keypad source: replays a packed BCD code as timed one-hot key
// presses (optional CLEAR, digits MSB-first, then ENTER) on the 16-bit
// keypad bus. Every key is held PRESS_TICKS cycles and followed by
// GAP_TICKS all-zero cycles, so the bus never jumps from key to key.
module keypad_replay_tx #(
  parameter int NUM_DIGITS  = 3,
  parameter int PRESS_TICKS = 1,
  parameter int GAP_TICKS   = 1,
  parameter int SEND_CLEAR  = 1
) (
  input  logic                    clk_1hz,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [4*NUM_DIGITS-1:0] code,
  output logic [15:0]             onehot,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  // Keys per run: optional CLEAR, every digit, then ENTER.
  localparam int KEYS      = SEND_CLEAR + NUM_DIGITS + 1;
  localparam int IDX_W     = $clog2(KEYS);
  localparam int MAX_TICKS = (PRESS_TICKS > GAP_TICKS) ? PRESS_TICKS : GAP_TICKS;
  localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

  localparam logic [CNT_W-1:0] PRESS_LAST = CNT_W'(PRESS_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_TICKS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(KEYS - 1);

  localparam logic [15:0] KEY_ENTER = 16'h0001;
  localparam logic [15:0] KEY_CLEAR = 16'h1000;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRESS = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]              state_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic [IDX_W-1:0]        idx_reg;
  logic [4*NUM_DIGITS-1:0] code_reg;
  logic [NUM_DIGITS-1:0]   nibble_bad;
  logic [15:0]             first_key;
  logic [15:0]             next_key;

  // Keypad wiring of the decimal digits.
  function automatic logic [15:0] digit_key(input logic [3:0] d);
    logic [15:0] k;
    case (d)
      4'd0:    k = 16'h0008;
      4'd1:    k = 16'h0080;
      4'd2:    k = 16'h0040;
      4'd3:    k = 16'h0020;
      4'd4:    k = 16'h0800;
      4'd5:    k = 16'h0400;
      4'd6:    k = 16'h0200;
      4'd7:    k = 16'h8000;
      4'd8:    k = 16'h4000;
      4'd9:    k = 16'h2000;
      default: k = 16'h0000;
    endcase
    return k;
  endfunction

  // Key at position i of the run; positions past the digits are ENTER.
  function automatic logic [15:0] key_at(input logic [IDX_W-1:0]        i,
                                         input logic [4*NUM_DIGITS-1:0] c);
    logic [15:0] k;
    k = KEY_ENTER;
    if (SEND_CLEAR != 0 && i == '0) k = KEY_CLEAR;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (i == IDX_W'(d + SEND_CLEAR)) k = digit_key(c[4*(NUM_DIGITS-1-d) +: 4]);
    end
    return k;
  endfunction

  // Flag every nibble of the incoming code that is not a decimal digit.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nibble_check
    assign nibble_bad[gi] = (code[4*gi +: 4] > 4'd9);
  end

  // First key comes straight from the port so it appears right after the start edge.
  always_comb begin
    first_key = key_at('0, code);
    next_key  = key_at(idx_reg + 1'b1, code_reg);
  end

  // Run sequencer: IDLE -> (PRESS -> GAP) per key -> IDLE with a done pulse.
  always_ff @(posedge clk_1hz or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      code_reg  <= '0;
      onehot    <= 16'h0000;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && state_reg != S_IDLE) begin
        state_reg <= S_IDLE;
        cnt_reg   <= '0;
        idx_reg   <= '0;
        onehot    <= 16'h0000;
        busy      <= 1'b0;
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (start) begin
              code_reg <= code;
              if (|nibble_bad) begin
                err <= 1'b1;
              end else begin
                err       <= 1'b0;
                busy      <= 1'b1;
                idx_reg   <= '0;
                cnt_reg   <= '0;
                onehot    <= first_key;
                state_reg <= S_PRESS;
              end
            end
          end
          S_PRESS: begin
            if (cnt_reg == PRESS_LAST) begin
              state_reg <= S_GAP;
              cnt_reg   <= '0;
              onehot    <= 16'h0000;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
          S_GAP: begin
            if (cnt_reg == GAP_LAST) begin
              cnt_reg <= '0;
              if (idx_reg == IDX_LAST) begin
                state_reg <= S_IDLE;
                idx_reg   <= '0;
                busy      <= 1'b0;
                done      <= 1'b1;
              end else begin
                idx_reg   <= idx_reg + 1'b1;
                onehot    <= next_key;
                state_reg <= S_PRESS;
              end
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
          default: begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            onehot    <= 16'h0000;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/keypad_replay_tx.md
Name: keypad_replay_tx

Overview:
- Scripted keypad source: converts a packed BCD code into timed one-hot key presses on the same 16-bit one-hot keypad bus the code-lock decoder consumes.
- Serves as the transmitter end of that bus, for the auto-demo mode and for self-test.
- Paced by the 1 Hz tick domain, so every press and release is human-scale and debounce-free at the lock.
- Sequence per run: optional CLEAR, then digits MSB-first, then ENTER.

Parameters:
- NUM_DIGITS, 3, number of BCD digits sent per run (1..4).
- PRESS_TICKS, 1, clk_1hz cycles each key is held (>=1).
- GAP_TICKS, 1, clk_1hz cycles of all-zero between keys (>=1).
- SEND_CLEAR, 1, 1 = prepend a CLEAR key (0x1000) to each run.

Ports:
- clk_1hz  input  1  pacing clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a run; sampled only when idle.
- abort  input  1  synchronous cancel; highest priority after reset.
- code  input  4*NUM_DIGITS  packed BCD; top nibble is sent first.
- onehot  output  16  registered keypad bus; 0x0000 means no key.
- busy  output  1  run in progress.
- done  output  1  one-cycle pulse when a run completes normally.
- err  output  1  sticky: last start request carried a nibble >9.

Behaviour:
- Reset: async, rst_n low forces onehot=0x0000, busy=0, done=0, err=0, state IDLE, all counters 0. Reset mid-run drops the run with no done pulse.
- Key map:
  - Digits: 0->0x0008, 1->0x0080, 2->0x0040, 3->0x0020, 4->0x0800, 5->0x0400, 6->0x0200, 7->0x8000, 8->0x4000, 9->0x2000.
  - Control keys: ENTER->0x0001, CLEAR->0x1000.
- States:
  - IDLE: onehot=0, busy=0.
  - PRESS: onehot=current key.
  - GAP: onehot=0.
  - The final GAP returns to IDLE.
- Start acceptance, in IDLE:
  - start=1 at edge E latches code and validates every nibble.
  - Any nibble >9: err<=1, stay IDLE, onehot stays 0.
  - All nibbles valid: err<=0, busy<=1, key index<=0, and at edge E onehot<=first key (CLEAR if SEND_CLEAR, else the top digit). The key is visible in the cycle after E; there is no extra latency.
- Key count K = SEND_CLEAR + NUM_DIGITS + 1.
- Timing:
  - PRESS lasts exactly PRESS_TICKS cycles, then GAP lasts exactly GAP_TICKS cycles.
  - Each GAP end loads the next key into onehot.
  - A run lasts K*(PRESS_TICKS+GAP_TICKS) cycles measured from edge E.
- Completion: at the edge ending the last GAP, busy<=0 and done<=1. done clears on the next edge. A start sampled at that same edge is ignored; a new run may begin from the following edge.
- onehot invariant: always 0x0000 or exactly one bit set. It never changes directly from one key to another without at least GAP_TICKS zero cycles between them.
- start while busy: ignored; the latched code is unaffected by changes on the code input.
- abort=1 at any edge while busy:
  - onehot<=0, busy<=0, state<=IDLE, no done pulse.
  - err is unchanged.
  - start at the same edge is ignored.
- abort in IDLE: no effect.
- Counters:
  - Tick counter is wide enough for max(PRESS_TICKS, GAP_TICKS) and saturates at no value; it is cleared on every state change.
  - Key index wraps only via the return to IDLE.

Test Plan:
- Normal run, defaults: code=0x246, start at edge 0. Required onehot after edges 0..9: 0x1000, 0, 0x0040, 0, 0x0800, 0, 0x0200, 0, 0x0001, 0. After edge 10: busy=0, done=1. After edge 11: done=0.
- Invalid code: code=0x2A6, start pulse. Required: err=1, busy=0, onehot stays 0x0000. A following start with 0x135 gives err=0 and sends 0x1000, 0x0080, 0x0020, 0x0400, 0x0001.
- Abort mid-run: code=0x789, abort asserted while onehot=0x4000. Required after that edge: onehot=0, busy=0, no done pulse. A later start replays the full sequence from CLEAR.
- Start while busy: a second start with code=0x000 during a 0x999 run. Required: the bus carries only 0x2000 digits, and exactly one done pulse occurs.
- Timing parameters: PRESS_TICKS=2, GAP_TICKS=3, SEND_CLEAR=0, code=0x101. Required: each key holds 2 cycles with 3 zero cycles between keys, keys are 0x0080, 0x0008, 0x0080, 0x0001, and done asserts 20 cycles after start.
- Async reset mid-press: rst_n low while onehot=0x0800. Required: onehot=0, busy=0, done=0, err=0 immediately, without waiting for a clk_1hz edge.
